ladybird_inst_fetch: RTL and testbench

//  Primary (initiator) side of ladybird_bus for instruction fetch. Issues sequential word reads
//  to an instruction memory secondary, tracks outstanding reads, and buffers returned words with

---
 rtl/ladybird_inst_fetch.sv | 171 +++++++++++++++++
 tb/tb_ladybird_inst_fetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_inst_fetch.sv
// ladybird_inst_fetch: instruction-fetch initiator on ladybird_bus.
// Issues sequential word reads, tracks in-flight reads with a credit scheme,
// buffers returned words with their PC in an in-order FIFO and serves decode
// through a valid/ready handshake. A redirect reloads the PC, flushes the
// buffer and marks every in-flight read as stale so its response is dropped.
// Optional feature macro: LADYBIRD_FETCH_EBREAK_STOP_EN (stop fetching after
// an EBREAK word enters the buffer, until the next redirect or reset).
module ladybird_inst_fetch #(
   parameter int unsigned      XLEN            = 32,
   parameter int unsigned      FIFO_DEPTH      = 4,
   parameter int unsigned      MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0]  RESET_PC        = '0
) (
   input  logic                 clk,
   input  logic                 arst,
   // ladybird_bus primary side
   output logic                 bus_req,
   output logic [XLEN-1:0]      bus_addr,
   output logic [XLEN/8-1:0]    bus_wstrb,
   input  logic                 bus_gnt,
   input  logic                 bus_data_gnt,
   inout  wire  [XLEN-1:0]      bus_data,
   // fetch control
   input  logic                 redirect_valid,
   input  logic [XLEN-1:0]      redirect_pc,
   // decode side
   output logic                 inst_valid,
   input  logic                 inst_ready,
   output logic [XLEN-1:0]      inst_data,
   output logic [XLEN-1:0]      inst_pc
);

   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned STRB_W = XLEN / 8;

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
   logic [OUT_W-1:0] outst_q, outst_d;
   logic [OUT_W-1:0] discard_q, discard_d;
   logic             stopped_q, stopped_d;
   logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [XLEN-1:0]  fifo_pc_q   [FIFO_DEPTH];
   logic [XLEN-1:0]  fifo_data_q [FIFO_DEPTH];

   logic             credit_c;
   logic             acc_c;
   logic             rsp_c;
   logic             push_c;
   logic             pop_c;
   logic             stop_set_c;
   logic [XLEN-1:0]  rdata_c;

   // Read-only initiator: never drives write strobes or the data bus
   assign bus_wstrb = STRB_W'(0);
   assign bus_data  = 'z;
   assign rdata_c   = bus_data;
   assign bus_addr  = fetch_pc_q;
   assign inst_pc   = fifo_pc_q[rd_ptr_q];
   assign inst_data = fifo_data_q[rd_ptr_q];

`ifdef LADYBIRD_FETCH_EBREAK_STOP_EN
   localparam logic [XLEN-1:0] EBREAK_WORD = XLEN'(32'h0010_0073);
   // Stop fetching once an EBREAK word is accepted into the buffer
   always_comb begin
      stop_set_c = push_c & (rdata_c == EBREAK_WORD);
   end
`else
   // Stop feature not built: fetch runs sequentially past EBREAK
   always_comb begin
      stop_set_c = 1'b0;
   end
`endif

   // Handshake decode: issue credits, accept, response and buffer push/pop
   always_comb begin
      credit_c   = (32'(fifo_cnt_q) + 32'(outst_q)) < FIFO_DEPTH;
      bus_req    = ~arst & ~redirect_valid & ~stopped_q
                   & (32'(outst_q) < MAX_OUTSTANDING) & credit_c;
      acc_c      = bus_req & bus_gnt;
      rsp_c      = bus_data_gnt & (outst_q != '0);
      push_c     = rsp_c & (discard_q == '0) & ~redirect_valid;
      inst_valid = (fifo_cnt_q != '0) & ~redirect_valid;
      pop_c      = inst_valid & inst_ready;
   end

   // Next-state for PC, in-flight accounting and buffer pointers
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      outst_d    = outst_q + OUT_W'(acc_c) - OUT_W'(rsp_c);
      discard_d  = discard_q;
      stopped_d  = stopped_q;
      fifo_cnt_d = fifo_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old stream
         fetch_pc_d = redirect_pc & ~XLEN'(3);
         rsp_pc_d   = redirect_pc & ~XLEN'(3);
         discard_d  = outst_q - OUT_W'(rsp_c);
         stopped_d  = 1'b0;
         fifo_cnt_d = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end else begin
         if (acc_c) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         if (push_c) begin
            rsp_pc_d = rsp_pc_q + XLEN'(4);
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         fifo_cnt_d = fifo_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
         if (stop_set_c) begin
            // Reads issued after the EBREAK are no longer wanted
            stopped_d = 1'b1;
            discard_d = outst_d;
         end else if (rsp_c && (discard_q != '0)) begin
            discard_d = discard_q - OUT_W'(1);
         end
      end
   end

   // Control state registers
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
         stopped_q  <= 1'b0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         stopped_q  <= stopped_d;
         fifo_cnt_q <= fifo_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Instruction buffer storage: word plus the PC it was fetched from
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            fifo_pc_q[i]   <= '0;
            fifo_data_q[i] <= '0;
         end
      end else if (push_c) begin
         fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
         fifo_data_q[wr_ptr_q] <= rdata_c;
      end
   end

   // A response with nothing in flight is a secondary protocol violation
   a_no_orphan_rsp: assert property (@(posedge clk) disable iff (arst)
      !(bus_data_gnt && (outst_q == '0)));

endmodule

// File: tb/tb_ladybird_inst_fetch.sv
// Bench for ladybird_inst_fetch: RAM-like secondary with programmable grant
// and latency, plus a stream-level reference model of what decode must see.
module tb_ladybird_inst_fetch;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned MAXO  = 2;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        arst;
   logic        bus_req;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic        bus_gnt;
   logic        bus_data_gnt;
   wire  [31:0] bus_data;
   logic [31:0] drv_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   assign bus_data = drv_data;

   always #5 clk = ~clk;

   ladybird_inst_fetch #(
      .XLEN(32), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .arst(arst),
      .bus_req(bus_req), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
      .bus_gnt(bus_gnt), .bus_data_gnt(bus_data_gnt), .bus_data(bus_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_pc(inst_pc)
   );

   typedef struct { logic [31:0] pc; int due; bit stale; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

   // reference model state
   pend_t       pend[$];     // reads accepted by the secondary, oldest first
   ent_t        fifo_m[$];   // instructions decode is entitled to see
   logic [31:0] req_pc;      // address of the next read to issue
   bit          stopped_m;

   // stimulus knobs
   int          cyc;
   int          gnt_mode;    // 0 always, 1 toggle, 2 random, 3 never
   int          lat_min, lat_max;
   bit          rsp_rand;
   bit          rv;
   logic [31:0] rpc;
   bit          plant;

   // observations
   int          vectors, miscompares;
   int          first_valid, acc_cnt, pop_cnt;
   bit          s_req, s_valid, saw_14;
   logic [31:0] s_pc, last_pop_pc;

   function automatic logic [31:0] memword(input logic [31:0] a);
      if (plant && a == 32'h10) return EBREAK;
      return {a[15:0] ^ a[31:16], ~a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: drive at negedge, compare, then advance the model past posedge
   task automatic step();
      bit    rsp, exp_req, exp_valid, acc, pop;
      pend_t r;
      case (gnt_mode)
         0:       bus_gnt = 1'b1;
         1:       bus_gnt = (cyc % 2) == 1;
         2:       bus_gnt = 1'($urandom_range(0, 1));
         default: bus_gnt = 1'b0;
      endcase
      rsp = pend.size() != 0 && pend[0].due <= cyc && (!rsp_rand || $urandom_range(0, 3) != 0);
      bus_data_gnt   = rsp;
      drv_data       = rsp ? memword(pend[0].pc) : $urandom();
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      exp_req = !rv && !stopped_m && pend.size() < MAXO &&
                (fifo_m.size() + pend.size()) < DEPTH;
      check("bus_req", 32'(bus_req), 32'(exp_req));
      if (exp_req) check("bus_addr", bus_addr, req_pc);
      check("bus_wstrb", 32'(bus_wstrb), 32'h0);
      exp_valid = fifo_m.size() != 0 && !rv;
      check("inst_valid", 32'(inst_valid), 32'(exp_valid));
      if (exp_valid) begin
         check("inst_pc", inst_pc, fifo_m[0].pc);
         check("inst_data", inst_data, fifo_m[0].data);
      end
      s_req = bus_req; s_valid = inst_valid; s_pc = inst_pc;
      if (inst_valid && first_valid < 0) first_valid = cyc;
      if (inst_valid && inst_ready) begin
         last_pop_pc = inst_pc;
         if (inst_pc == 32'h14) saw_14 = 1'b1;
      end
      acc = exp_req && bus_gnt;
      pop = exp_valid && inst_ready;
      if (acc) acc_cnt++;
      if (pop) begin
         pop_cnt++;
         void'(fifo_m.pop_front());
      end
      if (rsp) r = pend.pop_front();
      if (rv) begin
         foreach (pend[i]) pend[i].stale = 1'b1;
         fifo_m.delete();
         stopped_m = 1'b0;
         req_pc = rpc & ~32'h3;
      end else begin
         if (acc) begin
            pend.push_back('{pc: req_pc, due: cyc + $urandom_range(lat_min, lat_max), stale: 1'b0});
            req_pc = req_pc + 32'h4;
         end
         if (rsp && !r.stale) begin
            fifo_m.push_back('{pc: r.pc, data: drv_data});
`ifdef LADYBIRD_FETCH_EBREAK_STOP_EN
            if (drv_data == EBREAK) begin
               stopped_m = 1'b1;
               foreach (pend[i]) pend[i].stale = 1'b1;
            end
`endif
         end
      end
      rv = 1'b0;
      cyc++;
      @(negedge clk);
   endtask

   task automatic redirect(input logic [31:0] pc);
      rv = 1'b1; rpc = pc;
      step();
   endtask

   // Step until decode sees an instruction; its PC must be the new target
   task automatic wait_first_pc(input string tag, input logic [31:0] exp);
      int n = 0;
      do begin step(); n++; end while (!s_valid && n < 50);
      check(tag, s_valid ? s_pc : 32'hDEAD_BEEF, exp);
   endtask

   initial begin
      vectors = 0; miscompares = 0; cyc = 0;
      gnt_mode = 0; lat_min = 1; lat_max = 1; rsp_rand = 1'b0;
      rv = 1'b0; rpc = '0; plant = 1'b0; stopped_m = 1'b0; req_pc = 32'h0;
      first_valid = -1; acc_cnt = 0; pop_cnt = 0; saw_14 = 1'b0; last_pop_pc = '0;
      arst = 1'b1; bus_gnt = 1'b0; bus_data_gnt = 1'b0; drv_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

      // reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst_req", 32'(bus_req), 32'h0);
      check("rst_addr", bus_addr, 32'h0);
      check("rst_wstrb", 32'(bus_wstrb), 32'h0);
      check("rst_valid", 32'(inst_valid), 32'h0);
      check("rst_data", inst_data, 32'h0);
      check("rst_pc", inst_pc, 32'h0);
      @(negedge clk);
      arst = 1'b0;

      // 1: streaming from a 1-cycle RAM, one instruction per cycle
      inst_ready = 1'b1;
      repeat (12) step();
      check("t1_first_valid_cycle", 32'(first_valid), 32'd2);
      check("t1_pop_count", 32'(pop_cnt), 32'd10);

      // 2: decode stalled -> credits cap accepted reads at the buffer depth
      redirect(32'h100);
      inst_ready = 1'b0;
      acc_cnt = 0;
      repeat (12) step();
      check("t2_accepts", 32'(acc_cnt), 32'(DEPTH));
      check("t2_req_low", 32'(s_req), 32'h0);
      inst_ready = 1'b1;
      repeat (10) step();

      // 3: toggling grant, 2-cycle latency, random decode back-pressure
      gnt_mode = 1; lat_min = 2; lat_max = 2;
      repeat (40) begin inst_ready = 1'($urandom_range(0, 1)); step(); end
      inst_ready = 1'b1;

      // 4: redirect to unaligned PC with two reads in flight
      gnt_mode = 0; lat_min = 3; lat_max = 3;
      begin
         int n = 0;
         while (pend.size() != 2 && n < 20) begin step(); n++; end
         check("t4_inflight", 32'(pend.size()), 32'd2);
      end
      redirect(32'h43);
      wait_first_pc("t4_first_pc", 32'h40);
      repeat (6) step();

      // 5a: redirect coinciding with a response and a decode handshake
      lat_min = 1; lat_max = 1;
      repeat (6) step();
      redirect(32'h200);
      wait_first_pc("t5_flags_on", 32'h200);
      // 5b: redirect with no response and no handshake
      gnt_mode = 3; inst_ready = 1'b0;
      repeat (5) step();
      redirect(32'h300);
      gnt_mode = 0; inst_ready = 1'b1;
      wait_first_pc("t5_flags_off", 32'h300);

      // back-to-back redirects with stale reads still in flight
      lat_min = 3; lat_max = 3;
      repeat (4) step();
      redirect(32'h400);
      redirect(32'h500);
      redirect(32'h600);
      wait_first_pc("b2b_first_pc", 32'h600);

      // PC wrap at the top of the address space
      lat_min = 1; lat_max = 2;
      redirect(32'hFFFF_FFF4);
      wait_first_pc("wrap_first_pc", 32'hFFFF_FFF4);
      repeat (10) step();

      // 6: EBREAK planted at 0x10
      plant = 1'b1; lat_min = 1; lat_max = 1;
      redirect(32'h0);
      saw_14 = 1'b0; last_pop_pc = 32'hFFFF_FFFF;
      repeat (20) step();
`ifdef LADYBIRD_FETCH_EBREAK_STOP_EN
      check("t6_last_pc", last_pop_pc, 32'h10);
      check("t6_req_stays_low", 32'(s_req), 32'h0);
      redirect(32'h0);
      wait_first_pc("t6_restart_pc", 32'h0);
`else
      check("t6_past_ebreak", 32'(saw_14), 32'h1);
`endif
      plant = 1'b0;
      repeat (10) step();

      // randomized traffic with random redirects
      gnt_mode = 2; lat_min = 1; lat_max = 3; rsp_rand = 1'b1;
      repeat (1500) begin
         inst_ready = 1'($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) begin
            rv = 1'b1; rpc = $urandom();
         end
         step();
      end
      // drain: stop redirects, let every read land
      rsp_rand = 1'b0; inst_ready = 1'b1;
      repeat (20) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
